// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM port controller.
//   ADDR_W_DEFAULT / DATA_W_DEFAULT : default address and data widths
//   wr_state_e                      : write-FSM state encoding
package ram_ctrl_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 5;
    localparam int unsigned DATA_W_DEFAULT = 3;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StHold
    } wr_state_e;

endpackage

// File: rtl/ram_port_ctrl_sync2.sv
// Two-flop synchronizer for a group of asynchronous inputs.
//   CLK   : clock
//   reset : synchronous active-high reset, loads RST_VAL into both stages
//   d_i   : asynchronous input bus
//   q_o   : synchronized output bus
module sync2 #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ram_port_ctrl.sv
// RAM port controller: one RAM write per pushbutton press from switch inputs,
// plus a free-running read-address scan advancing once every DIV clocks.
//   CLK, reset        : clock, synchronous active-high reset
//   sw_addr, sw_data  : asynchronous switch write address / data
//   key_n             : asynchronous active-low write button
//   pause             : scan hold (only honoured when SCAN_PAUSE_EN is defined)
//   wr_addr, wr_data  : registered write address / data
//   wr_en             : one-cycle write strobe
//   rd_addr           : scanning read address
//   step              : one-cycle pulse on each rd_addr advance
// Optional feature macro: SCAN_PAUSE_EN.
module ram_port_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DIV    = 50_000_000
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              key_n,
    input  logic              pause,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              step
);

    localparam int unsigned      CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    // ---------------- input synchronizers ----------------
    logic              key_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;

    // Key idles high (released) so reset never looks like a press.
    sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_key (
        .CLK   (CLK),
        .reset (reset),
        .d_i   (key_n),
        .q_o   (key_s)
    );

    sync2 #(.WIDTH(ADDR_W), .RST_VAL('0)) u_sync_addr (
        .CLK   (CLK),
        .reset (reset),
        .d_i   (sw_addr),
        .q_o   (addr_s)
    );

    sync2 #(.WIDTH(DATA_W), .RST_VAL('0)) u_sync_data (
        .CLK   (CLK),
        .reset (reset),
        .d_i   (sw_data),
        .q_o   (data_s)
    );

    // ---------------- write FSM ----------------
    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= StIdle;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            StIdle: begin
                if (!key_s) begin
                    state_d   = StWrite;
                    wr_addr_d = addr_s;
                    wr_data_d = data_s;
                end
            end
            StWrite: state_d = StHold;
            StHold:  if (key_s) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign wr_en   = (state_q == StWrite);
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    // ---------------- read-address scan ----------------
    logic scan_hold;

`ifdef SCAN_PAUSE_EN
    assign scan_hold = pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign scan_hold    = 1'b0;
`endif

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              step_q, step_d;

    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q     <= '0;
            rd_addr_q <= '0;
            step_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rd_addr_q <= rd_addr_d;
            step_q    <= step_d;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        step_d    = 1'b0;
        if (!scan_hold) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d     = '0;
                step_d    = 1'b1;
                rd_addr_d = rd_addr_q + ADDR_W'(1);  // wraps naturally at 2^ADDR_W
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign rd_addr = rd_addr_q;
    assign step    = step_q;

endmodule

// File: tb/tb_ram_port_ctrl.sv
module tb_ram_port_ctrl;

    localparam int unsigned AW  = 5;
    localparam int unsigned DW  = 3;
    localparam int unsigned DIV = 4;

    logic          CLK = 1'b0;
    logic          reset;
    logic [AW-1:0] sw_addr;
    logic [DW-1:0] sw_data;
    logic          key_n;
    logic          pause;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic [AW-1:0] rd_addr;
    logic          step;

    ram_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DIV(DIV)) dut (
        .CLK     (CLK),
        .reset   (reset),
        .sw_addr (sw_addr),
        .sw_data (sw_data),
        .key_n   (key_n),
        .pause   (pause),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .rd_addr (rd_addr),
        .step    (step)
    );

    always #5 CLK = ~CLK;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Scoreboard: expected writes pushed when a press is driven, observed writes
    // collected each cycle.
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] obs_q[$];
    int unsigned      step_cnt;
    int unsigned      tick_no;
    int               first_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        tick_no++;
        if (wr_en) begin
            obs_q.push_back({wr_addr, wr_data});
            if (first_wr < 0) first_wr = int'(tick_no);
        end
        if (step) step_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        obs_q.delete();
        step_cnt = 0;
        tick_no  = 0;
        first_wr = -1;
    endtask

    task automatic drain(input string tag);
        logic [AW+DW-1:0] e, o;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_data"}, 32'(o), 32'(e));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        reset    = 1'b1;
        sw_addr  = '0;
        sw_data  = '0;
        key_n    = 1'b1;
        pause    = 1'b0;
        step_cnt = 0;
        tick_no  = 0;
        first_wr = -1;

        // Reset values, then first step exactly DIV cycles after release.
        ticks(3);
        do_reset();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_step", step, 0);
        ticks(3);
        chk("pre_step", step_cnt, 0);
        tick();
        chk("first_step", step, 1);
        chk("first_rd_addr", rd_addr, 1);

        // Full scan wrap: 32 steps in 128 cycles.
        do_reset();
        ticks(124);
        chk("rd_addr_31", rd_addr, 31);
        ticks(4);
        chk("wrap_rd_addr", rd_addr, 0);
        chk("wrap_steps", step_cnt, 32);

        // Long press: one write, fixed sync+FSM latency.
        do_reset();
        sw_addr = 5'd17;
        sw_data = 3'd5;
        key_n   = 1'b0;
        exp_q.push_back({5'd17, 3'd5});
        ticks(20);
        key_n = 1'b1;
        ticks(5);
        chk("wr_latency", first_wr, 3);
        drain("press_long");
        chk("hold_wr_addr", wr_addr, 17);
        chk("hold_wr_data", wr_data, 5);

        // Switches change during HOLD: captured values must not move.
        first_wr = -1;
        tick_no  = 0;
        key_n    = 1'b0;
        exp_q.push_back({5'd17, 3'd5});
        ticks(8);
        sw_addr = 5'd9;
        sw_data = 3'd2;
        ticks(12);
        chk("mid_hold_wr_data", wr_data, 5);
        chk("mid_hold_wr_addr", wr_addr, 17);
        key_n = 1'b1;
        ticks(5);
        drain("press_sw_change");

        // Short press picks up the new switch values.
        key_n = 1'b0;
        exp_q.push_back({5'd9, 3'd2});
        ticks(4);
        key_n = 1'b1;
        ticks(5);
        drain("press_short");

        // Reset during HOLD with key held: aborted, then exactly one new write.
        sw_addr = 5'd25;
        sw_data = 3'd6;
        key_n   = 1'b0;
        exp_q.push_back({5'd25, 3'd6});
        ticks(6);
        drain("press_pre_reset");
        do_reset();
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_wr_en", wr_en, 0);
        exp_q.push_back({5'd25, 3'd6});
        ticks(10);
        key_n = 1'b1;
        ticks(5);
        drain("press_post_reset");

        // Scan pause at rd_addr=3.
        do_reset();
        ticks(12);
        chk("pause_start_rd", rd_addr, 3);
        step_cnt = 0;
        pause    = 1'b1;
        ticks(20);
`ifdef SCAN_PAUSE_EN
        chk("pause_rd_addr", rd_addr, 3);
        chk("pause_steps", step_cnt, 0);
`else
        chk("nopause_rd_addr", rd_addr, 8);
        chk("nopause_steps", step_cnt, 5);
`endif
        pause = 1'b0;
        ticks(4);
`ifdef SCAN_PAUSE_EN
        chk("resume_rd_addr", rd_addr, 4);
`else
        chk("resume_rd_addr", rd_addr, 9);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_port_ctrl.md
RAM_PORT_CTRL -- requirements
Module: ram_port_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning address width (32 words).
REQ-002 SHALL have parameter DATA_W, default 3, meaning data word width.
REQ-003 SHALL have parameter DIV, default 50_000_000, meaning CLK cycles per read-address step (1 Hz at 50 MHz).
REQ-004 SHALL have port CLK, input, 1, meaning the single clock.
REQ-005 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port sw_addr, input, ADDR_W, meaning asynchronous switch write address.
REQ-007 SHALL have port sw_data, input, DATA_W, meaning asynchronous switch write data.
REQ-008 SHALL have port key_n, input, 1, meaning asynchronous active-low write pushbutton.
REQ-009 SHALL have port pause, input, 1, meaning scan hold request (see Configuration).
REQ-010 SHALL have port wr_addr, output, ADDR_W, meaning registered RAM write address.
REQ-011 SHALL have port wr_data, output, DATA_W, meaning registered RAM write data.
REQ-012 SHALL have port wr_en, output, 1, meaning one-cycle RAM write strobe.
REQ-013 SHALL have port rd_addr, output, ADDR_W, meaning RAM read address for display.
REQ-014 SHALL have port step, output, 1, meaning one-cycle pulse on each rd_addr advance.

Function
REQ-015 SHALL pass key_n, sw_addr and sw_data each through a two-flop synchronizer before any use.
REQ-016 SHALL run write FSM states IDLE, WRITE, HOLD.
REQ-017 SHALL move IDLE->WRITE on the first cycle synchronized key_n is low.
REQ-018 SHALL, in WRITE, assert wr_en for exactly one cycle with wr_addr/wr_data captured from synchronized switches on the IDLE->WRITE transition, then go to HOLD.
REQ-019 SHALL stay in HOLD while synchronized key_n is low and return to IDLE on the first cycle it is high; one press yields exactly one write regardless of hold length.
REQ-020 SHALL hold wr_addr/wr_data stable outside the capture cycle; switch changes during WRITE/HOLD are ignored.
REQ-021 SHALL keep a divider counter 0..DIV-1; on reaching DIV-1 it wraps to 0, pulses step for one cycle and increments rd_addr.
REQ-022 SHALL wrap rd_addr from 2^ADDR_W-1 to 0.
REQ-023 SHALL let wr_en and step coincide with no interaction; rd_addr equal to wr_addr is permitted and not flagged.
REQ-024 SHALL have latency of 2 sync cycles plus 1 FSM cycle from key_n fall to wr_en high (wr_en in 3rd or 4th cycle after fall, depending on edge alignment).

Reset
REQ-025 SHALL, with reset high at a CLK edge, set FSM to IDLE, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, step=0, divider=0, synchronizer flops to idle values (key high, switches 0).
REQ-026 SHALL abort any write in progress on reset; a key still held after reset release SHALL produce a new write (FSM restarts in IDLE).

Configuration
REQ-027 SHALL, with SCAN_PAUSE_EN defined, freeze divider and rd_addr (step=0) while pause is high, resuming from the frozen count.
REQ-028 SHALL, without SCAN_PAUSE_EN, ignore pause entirely.

Structure
REQ-029 SHALL place write-FSM state enum and ADDR_W/DATA_W defaults in shared package ram_ctrl_pkg.
REQ-030 SHALL implement the two-flop synchronizer as sub-module sync2 (parameterized width), instantiated per input group.

Verification (DIV=4 in bench)
REQ-031 SHALL check reset: all outputs 0 cycle after reset; 4 cycles later step=1, rd_addr=1.
REQ-032 SHALL check wrap: run 128 cycles from reset -> rd_addr returns to 0, exactly 32 step pulses.
REQ-033 SHALL check write: sw_addr=5'd17, sw_data=3'd5, key_n low 20 cycles -> exactly one wr_en pulse with wr_addr=17, wr_data=5.
REQ-034 SHALL check switch change during HOLD: sw_data changed to 3'd2 mid-press -> wr_data stays 5, no second wr_en.
REQ-035 SHALL check reset mid-press: reset during HOLD, key still low -> one new wr_en after reset release.
REQ-036 SHALL check pause (SCAN_PAUSE_EN defined): pause high at rd_addr=3 for 20 cycles -> rd_addr stays 3, no step; resumes afterward. Without the macro, rd_addr advances.
